ps2_key_tx: RTL

Emulates a PS/2 keyboard for one decimal key: on request, sends the full keystroke for digit 0-9 on the PS/2 clock/data lines. The keystroke is three frames: make code, break prefix 0xF0, then the make code again. It sits on the stimulus/emulation side of the keyboard path and drives the same two-wire bus the PS/2 receive chain and digit decoder consume. It is used both for self-test loopback and for driving keypad logic without a physical keyboard.

---
 rtl/ps2_pkg.sv | 43 ++++
 rtl/ps2_key_tx_if.sv | 13 +
 rtl/ps2_frame_tx.sv | 96 +++++++++
 rtl/ps2_key_tx.sv | 120 ++++++++++++
 4 files changed

// File: rtl/ps2_pkg.sv
// rtl/ps2_pkg.sv - shared constants, FSM state type and make-code lookup for the PS/2 key emulator
package ps2_pkg;

  localparam logic [7:0] KEY_0 = 8'h45;
  localparam logic [7:0] KEY_1 = 8'h16;
  localparam logic [7:0] KEY_2 = 8'h1E;
  localparam logic [7:0] KEY_3 = 8'h26;
  localparam logic [7:0] KEY_4 = 8'h25;
  localparam logic [7:0] KEY_5 = 8'h2E;
  localparam logic [7:0] KEY_6 = 8'h36;
  localparam logic [7:0] KEY_7 = 8'h3D;
  localparam logic [7:0] KEY_8 = 8'h3E;
  localparam logic [7:0] KEY_9 = 8'h46;

  localparam logic [7:0] BREAK_PREFIX = 8'hF0;
  localparam int         FRAME_BITS   = 11;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SEND,
    ST_GAP
  } state_t;

  function automatic logic [7:0] make_code(input logic [3:0] digit);
    logic [7:0] code;
    code = 8'h00;
    case (digit)
      4'd0:    code = KEY_0;
      4'd1:    code = KEY_1;
      4'd2:    code = KEY_2;
      4'd3:    code = KEY_3;
      4'd4:    code = KEY_4;
      4'd5:    code = KEY_5;
      4'd6:    code = KEY_6;
      4'd7:    code = KEY_7;
      4'd8:    code = KEY_8;
      4'd9:    code = KEY_9;
      default: code = 8'h00;
    endcase
    return code;
  endfunction

endpackage

// File: rtl/ps2_key_tx_if.sv
// rtl/ps2_key_tx_if.sv - request/status handshake and PS/2 bus lines of the key emulator
interface ps2_key_tx_if;
  logic       start;
  logic [3:0] num;
  logic       ready;
  logic       done;
  logic       err;
  logic       ps2_clk;
  logic       ps2_data;

  modport master (output start, num, input ready, done, err, ps2_clk, ps2_data);
  modport slave  (input start, num, output ready, done, err, ps2_clk, ps2_data);
endinterface

// File: rtl/ps2_frame_tx.sv
// rtl/ps2_frame_tx.sv - serialises one byte as an 11-cell PS/2 frame (start, 8 data LSB first, odd parity, stop)
module ps2_frame_tx
  import ps2_pkg::*;
#(
  parameter int HALF_PERIOD = 2500
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       load_i,
  input  logic [7:0] byte_i,
  output logic       busy_o,
  output logic       frame_done_o,
  output logic       ps2_clk_o,
  output logic       ps2_data_o
);

  localparam int              HW        = $clog2(HALF_PERIOD);
  localparam logic [HW-1:0]   HALF_LAST = HW'(HALF_PERIOD - 1);
  localparam logic [3:0]      BIT_LAST  = 4'(FRAME_BITS - 1);

  logic                  busy_q, busy_d;
  logic                  phase_q, phase_d;
  logic [HW-1:0]         half_q, half_d;
  logic [3:0]            bit_q, bit_d;
  logic [FRAME_BITS-1:0] shift_q, shift_d;
  logic                  clk_q, clk_d;
  logic                  data_q, data_d;

  logic half_end;
  assign half_end     = busy_q && (half_q == HALF_LAST);
  assign frame_done_o = half_end && phase_q && (bit_q == BIT_LAST);

  always_comb begin
    busy_d  = busy_q;
    phase_d = phase_q;
    half_d  = half_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    clk_d   = clk_q;
    data_d  = data_q;
    if (load_i) begin
      // shift_q[0] is always the bit currently on the line; the start bit goes out immediately
      shift_d = {1'b1, ~^byte_i, byte_i, 1'b0};
      busy_d  = 1'b1;
      phase_d = 1'b0;
      half_d  = '0;
      bit_d   = '0;
      clk_d   = 1'b1;
      data_d  = 1'b0;
    end else if (busy_q) begin
      if (half_end) begin
        half_d  = '0;
        phase_d = ~phase_q;
        if (!phase_q) begin
          clk_d = 1'b0;
        end else if (bit_q == BIT_LAST) begin
          busy_d = 1'b0;
          clk_d  = 1'b1;
          data_d = 1'b1;
        end else begin
          bit_d   = bit_q + 4'd1;
          shift_d = {1'b1, shift_q[FRAME_BITS-1:1]};
          clk_d   = 1'b1;
          data_d  = shift_q[1];
        end
      end else begin
        half_d = half_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      busy_q  <= 1'b0;
      phase_q <= 1'b0;
      half_q  <= '0;
      bit_q   <= '0;
      shift_q <= '1;
      clk_q   <= 1'b1;
      data_q  <= 1'b1;
    end else begin
      busy_q  <= busy_d;
      phase_q <= phase_d;
      half_q  <= half_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      clk_q   <= clk_d;
      data_q  <= data_d;
    end
  end

  assign busy_o     = busy_q;
  assign ps2_clk_o  = clk_q;
  assign ps2_data_o = data_q;

endmodule

// File: rtl/ps2_key_tx.sv
// rtl/ps2_key_tx.sv - sequences make / break prefix / make frames with idle gaps for one decimal key
module ps2_key_tx
  import ps2_pkg::*;
#(
  parameter int HALF_PERIOD = 2500,
  parameter int BYTE_GAP    = 5000
) (
  input logic          clk_i,
  input logic          rst_i,
  ps2_key_tx_if.slave  bus_if
);

  localparam int            GW       = $clog2(BYTE_GAP + 1);
  localparam logic [GW-1:0] GAP_LAST = GW'(BYTE_GAP - 1);

  state_t        state_q, state_d;
  logic [1:0]    byte_idx_q, byte_idx_d;
  logic [GW-1:0] gap_q, gap_d;
  logic [7:0]    code_q, code_d;
  logic          ready_q, ready_d;
  logic          done_q, done_d;
  logic          err_q, err_d;

  logic       load;
  logic [7:0] load_byte;
  logic       frame_busy;
  logic       frame_done;

  always_comb begin
    state_d    = state_q;
    byte_idx_d = byte_idx_q;
    gap_d      = gap_q;
    code_d     = code_q;
    ready_d    = ready_q;
    done_d     = 1'b0;
    err_d      = 1'b0;
    load       = 1'b0;
    load_byte  = code_q;
    case (state_q)
      ST_IDLE: begin
        if (bus_if.start) begin
          if (bus_if.num > 4'd9) begin
            err_d = 1'b1;
          end else begin
            code_d     = make_code(bus_if.num);
            load       = !frame_busy;
            load_byte  = make_code(bus_if.num);
            byte_idx_d = 2'd0;
            ready_d    = 1'b0;
            state_d    = ST_SEND;
          end
        end
      end
      ST_SEND: begin
        if (frame_done) begin
          gap_d   = '0;
          state_d = ST_GAP;
        end
      end
      ST_GAP: begin
        if (gap_q == GAP_LAST) begin
          gap_d = '0;
          if (byte_idx_q < 2'd2) begin
            // byte 1 is the break prefix, byte 2 repeats the make code
            byte_idx_d = byte_idx_q + 2'd1;
            load       = !frame_busy;
            load_byte  = (byte_idx_q == 2'd0) ? BREAK_PREFIX : code_q;
            state_d    = ST_SEND;
          end else begin
            done_d  = 1'b1;
            ready_d = 1'b1;
            state_d = ST_IDLE;
          end
        end else begin
          gap_d = gap_q + 1'b1;
        end
      end
      default: begin
        ready_d = 1'b1;
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= ST_IDLE;
      byte_idx_q <= '0;
      gap_q      <= '0;
      code_q     <= '0;
      ready_q    <= 1'b1;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      byte_idx_q <= byte_idx_d;
      gap_q      <= gap_d;
      code_q     <= code_d;
      ready_q    <= ready_d;
      done_q     <= done_d;
      err_q      <= err_d;
    end
  end

  ps2_frame_tx #(.HALF_PERIOD(HALF_PERIOD)) u_frame_tx (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .load_i       (load),
    .byte_i       (load_byte),
    .busy_o       (frame_busy),
    .frame_done_o (frame_done),
    .ps2_clk_o    (bus_if.ps2_clk),
    .ps2_data_o   (bus_if.ps2_data)
  );

  assign bus_if.ready = ready_q;
  assign bus_if.done  = done_q;
  assign bus_if.err   = err_q;

endmodule
